// File: rtl/board_state_ctrl.sv
// Minesweeper 8x8 game-state writer: cursor, flags, reveals, mine placement.
// Define WRAP_CURSOR_EN to make cursor moves wrap within a row/column.
module board_state_ctrl #(
    parameter int unsigned MINE_COUNT = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_flag,
    input  logic        btn_step,
    input  logic        btn_new,
    output logic [63:0] mineMap,
    output logic [63:0] flagMap,
    output logic [63:0] stepMap,
    output logic [63:0] posMap,
    output logic        busy,
    output logic        game_over,
    output logic        game_won
);

    typedef enum logic [2:0] {
        IDLE,
        PLACE,
        PLAY,
        LOST,
        WON
    } state_t;

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_FLAG  = 4;
    localparam int B_STEP  = 5;
    localparam int B_NEW   = 6;

    localparam logic [6:0]  MINES = 7'(MINE_COUNT);
    localparam logic [6:0]  SAFE  = 7'(64 - MINE_COUNT);
    localparam logic [15:0] POLY  = 16'hB400;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [63:0] mine_q, mine_d;
    logic [63:0] flag_q, flag_d;
    logic [63:0] step_q, step_d;
    logic [5:0]  cur_q, cur_d;
    logic [6:0]  mcnt_q, mcnt_d;
    logic [6:0]  scnt_q, scnt_d;
    logic [6:0]  prev_q;

    logic [6:0]  btn;
    logic [6:0]  rise;
    logic [5:0]  cand;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [5:0]  cur_up;
    logic [5:0]  cur_dn;
    logic [5:0]  cur_lt;
    logic [5:0]  cur_rt;
    logic [63:0] cur_oh;

    assign btn    = {btn_new, btn_step, btn_flag,
                     btn_right, btn_left, btn_down, btn_up};
    assign rise   = btn & ~prev_q;
    assign cand   = lfsr_q[5:0];
    assign row    = cur_q[5:3];
    assign col    = cur_q[2:0];
    assign cur_oh = 64'd1 << cur_q;

`ifdef WRAP_CURSOR_EN
    assign cur_up = {row - 3'd1, col};
    assign cur_dn = {row + 3'd1, col};
    assign cur_lt = {row, col - 3'd1};
    assign cur_rt = {row, col + 3'd1};
`else
    assign cur_up = (row == 3'd0) ? cur_q : {row - 3'd1, col};
    assign cur_dn = (row == 3'd7) ? cur_q : {row + 3'd1, col};
    assign cur_lt = (col == 3'd0) ? cur_q : {row, col - 3'd1};
    assign cur_rt = (col == 3'd7) ? cur_q : {row, col + 3'd1};
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
        mine_d  = mine_q;
        flag_d  = flag_q;
        step_d  = step_q;
        cur_d   = cur_q;
        mcnt_d  = mcnt_q;
        scnt_d  = scnt_q;

        // New game wins over everything, in every state.
        if (rise[B_NEW]) begin
            state_d = PLACE;
            mine_d  = '0;
            flag_d  = '0;
            step_d  = '0;
            cur_d   = '0;
            mcnt_d  = '0;
            scnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: ;
                PLACE: begin
                    if (!mine_q[cand]) begin
                        mine_d[cand] = 1'b1;
                        mcnt_d       = mcnt_q + 7'd1;
                        if (mcnt_d == MINES) begin
                            state_d = PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (rise[B_STEP]) begin
                        if (flag_q[cur_q] || step_q[cur_q]) begin
                            step_d = step_q;
                        end else if (mine_q[cur_q]) begin
                            step_d  = step_q | mine_q | cur_oh;
                            state_d = LOST;
                        end else begin
                            step_d[cur_q] = 1'b1;
                            scnt_d        = scnt_q + 7'd1;
                            if (scnt_d == SAFE) begin
                                state_d = WON;
                            end
                        end
                    end else if (rise[B_FLAG]) begin
                        if (!step_q[cur_q]) begin
                            flag_d[cur_q] = ~flag_q[cur_q];
                        end
                    end else if (rise[B_UP]) begin
                        cur_d = cur_up;
                    end else if (rise[B_DOWN]) begin
                        cur_d = cur_dn;
                    end else if (rise[B_LEFT]) begin
                        cur_d = cur_lt;
                    end else if (rise[B_RIGHT]) begin
                        cur_d = cur_rt;
                    end
                end
                LOST, WON: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            mine_q  <= '0;
            flag_q  <= '0;
            step_q  <= '0;
            cur_q   <= '0;
            mcnt_q  <= '0;
            scnt_q  <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            mine_q  <= mine_d;
            flag_q  <= flag_d;
            step_q  <= step_d;
            cur_q   <= cur_d;
            mcnt_q  <= mcnt_d;
            scnt_q  <= scnt_d;
            prev_q  <= btn;
        end
    end

    assign mineMap   = mine_q;
    assign flagMap   = flag_q;
    assign stepMap   = step_q;
    assign posMap    = cur_oh;
    assign busy      = (state_q == PLACE);
    assign game_over = (state_q == LOST);
    assign game_won  = (state_q == WON);

endmodule

// File: doc/board_state_ctrl.md
Name: board_state_ctrl

Overview:
Game-state writer for the 8x8 minesweeper board. It owns the four 64-bit tile maps (mine, flag, step, cursor position) that the board renderer reads every frame. It turns debounced button levels into cursor moves, flag toggles and tile reveals, and places mines pseudo-randomly at the start of each game. It sits between the key/switch front end and the renderer; tile n is at row n[5:3], column n[2:0], with row 0 at the top.

Parameters:
MINE_COUNT, 10, mines placed per game; legal range 1..63.
LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
btn_up  input  1  level, debounced; move cursor up one row
btn_down  input  1  level; move cursor down one row
btn_left  input  1  level; move cursor left one column
btn_right  input  1  level; move cursor right one column
btn_flag  input  1  level; toggle flag on cursor tile
btn_step  input  1  level; reveal cursor tile
btn_new  input  1  level; start a new game
mineMap  output  64  bit n = 1 means tile n holds a mine
flagMap  output  64  bit n = 1 means tile n is flagged
stepMap  output  64  bit n = 1 means tile n is revealed
posMap  output  64  one-hot cursor, bit n = 1 means the cursor is on tile n
busy  output  1  high while in PLACE
game_over  output  1  high in LOST
game_won  output  1  high in WON

Behaviour:
- Reset (reset == 0 at a posedge):
  - All maps go to 0 except posMap = 64'h1 (cursor at tile 0).
  - State goes to IDLE; busy, game_over and game_won go to 0.
  - LFSR loads LFSR_SEED; mine counter and step counter go to 0.
  - All button-history registers go to 0.
- Edge detection:
  - Each button has a previous-value register.
  - An action fires on a posedge where btn = 1 and prev = 0.
  - Map and state updates land on that same edge, so they are visible one cycle after the button is first sampled high.
  - Holding a button produces exactly one action.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). It advances every cycle outside reset, so player timing seeds later games.
- FSM states and transitions:
  - IDLE: only btn_new acts. On btn_new, go to PLACE.
  - Entering PLACE: clear mineMap, flagMap and stepMap; cursor to tile 0; both counters to 0.
  - PLACE: each cycle take candidate = lfsr[5:0].
    - If mineMap[candidate] = 0, set the bit and increment the mine counter.
    - Otherwise take no action that cycle.
    - When the counter reaches MINE_COUNT, go to PLAY.
    - Latency is variable, at least MINE_COUNT cycles.
    - Buttons other than btn_new are ignored in PLACE.
  - PLAY: at most one action per cycle. Priority is new > step > flag > up > down > left > right; lower-priority edges on the same cycle are discarded.
    - step on a flagged or already-revealed tile: no effect.
    - step on a safe tile: set stepMap[cursor] and increment the step counter.
    - step on a mined tile: stepMap |= mineMap | (1 << cursor), then go to LOST.
    - After the increment, if the step counter = 64 - MINE_COUNT, go to WON.
    - flag: toggles flagMap[cursor] only when stepMap[cursor] = 0.
    - moves: saturate at board edges. At row 0, up is a no-op; at column 7, right is a no-op; likewise for down and left.
    - posMap always equals 1 << cursor.
  - LOST / WON: maps are frozen; game_over or game_won is held high; btn_new goes to PLACE.
- btn_new in any state, including mid-PLACE, restarts PLACE with cleared maps.
- Reset in any state overrides everything on the same edge.
- Maps are registered outputs with no combinational path from the buttons.

Optional Feature:
WRAP_CURSOR_EN
- Defined: cursor moves wrap within the row or column (mod-8 on row and column separately). Example: right at column 7 goes to column 0 of the same row; up at row 0 goes to row 7.
- Undefined: moves saturate at the edges as described under Behaviour.
- No other behaviour changes.

Test Plan:
- Reset with all buttons low, then pulse btn_new and wait until busy falls.
  - After reset: mineMap = flagMap = stepMap = 0 and posMap = 64'h1.
  - After placement: popcount(mineMap) = 10 and the state is PLAY.
- Hold btn_right for 20 cycles, then release → cursor at tile 1 only (one action per edge). Then 3 separate btn_down pulses → posMap = 1 << 25.
- From tile 0, pulse btn_up and then btn_left.
  - Without the macro: posMap stays 64'h1.
  - With WRAP_CURSOR_EN: up moves to tile 56, then left moves to tile 63.
- Move to a non-mined tile T and pulse btn_flag, then btn_step, then btn_flag.
  - First btn_flag: flagMap[T] = 1.
  - btn_step while flagged: stepMap unchanged.
  - Second btn_flag: flagMap[T] = 0.
  - A further btn_step sets stepMap[T] = 1. A repeat step leaves the internal step count unchanged.
- Navigate to a mined tile M and pulse btn_step → game_over = 1 the next cycle, stepMap[M] = 1 and stepMap ⊇ mineMap. Further moves and steps change nothing. btn_new → busy = 1 and all maps are cleared.
- Step every one of the 54 safe tiles → game_won asserts on the cycle after the 54th step, and game_over stays 0. Pulse btn_step and btn_flag in the same cycle → only the step is applied.
